// File: rtl/bcd_uart_tx_if.sv
// rtl/bcd_uart_tx_if.sv - start/digits request and UART status bundle for bcd_uart_tx
interface bcd_uart_tx_if;
    logic        i_start;
    logic [31:0] i_digits;
    logic        o_tx;
    logic        o_busy;
    logic        o_done;

    modport slave  (input  i_start, i_digits, output o_tx, o_busy, o_done);
    modport master (output i_start, i_digits, input  o_tx, o_busy, o_done);
endinterface

// File: rtl/bcd_uart_tx.sv
// rtl/bcd_uart_tx.sv - sends an 8-digit BCD number as ASCII over 8N1 UART, optional CR LF
module bcd_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter bit APPEND_CRLF  = 1'b1
) (
    input  logic        i_iclk,
    input  logic        i_rst,
    bcd_uart_tx_if.slave bus
);
    localparam int BW      = $clog2(CLKS_PER_BIT);
    localparam int N_CHARS = APPEND_CRLF ? 10 : 8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      r_state, w_state_nxt;
    logic [BW-1:0] r_baud, w_baud_nxt;
    logic [2:0]  r_bit, w_bit_nxt;
    logic [3:0]  r_char, w_char_nxt;
    logic [31:0] r_msg, w_msg_nxt;
    logic [6:0]  r_shift, w_shift_nxt;
    logic        r_tx, w_tx_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_done, w_done_nxt;

    logic [3:0]  w_nib;
    logic [7:0]  w_char;
    logic        w_baud_last;

    assign w_baud_last = (r_baud == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        w_nib = 4'h0;
        case (r_char)
            4'd0:    w_nib = r_msg[31:28];
            4'd1:    w_nib = r_msg[27:24];
            4'd2:    w_nib = r_msg[23:20];
            4'd3:    w_nib = r_msg[19:16];
            4'd4:    w_nib = r_msg[15:12];
            4'd5:    w_nib = r_msg[11:8];
            4'd6:    w_nib = r_msg[7:4];
            4'd7:    w_nib = r_msg[3:0];
            default: w_nib = 4'h0;
        endcase
        if (r_char == 4'd8)
            w_char = 8'h0D;
        else if (r_char == 4'd9)
            w_char = 8'h0A;
        else if (w_nib <= 4'd9)
            w_char = {4'h3, w_nib};
        else
            w_char = 8'h3F;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_char_nxt  = r_char;
        w_msg_nxt   = r_msg;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                // A start arriving while the done pulse is still visible is dropped
                if (bus.i_start && !r_done) begin
                    w_state_nxt = START;
                    w_msg_nxt   = bus.i_digits;
                    w_char_nxt  = 4'd0;
                    w_baud_nxt  = '0;
                    w_tx_nxt    = 1'b0;
                    w_busy_nxt  = 1'b1;
                end
            end
            START: begin
                if (w_baud_last) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_shift_nxt = w_char[7:1];
                    w_tx_nxt    = w_char[0];
                    w_state_nxt = DATA;
                end else begin
                    w_baud_nxt = r_baud + BW'(1);
                end
            end
            DATA: begin
                if (w_baud_last) begin
                    w_baud_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_tx_nxt    = r_shift[0];
                        w_shift_nxt = {1'b0, r_shift[6:1]};
                    end
                end else begin
                    w_baud_nxt = r_baud + BW'(1);
                end
            end
            STOP: begin
                if (w_baud_last) begin
                    w_baud_nxt = '0;
                    if (r_char < 4'(N_CHARS - 1)) begin
                        w_char_nxt  = r_char + 4'd1;
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = START;
                    end else begin
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud + BW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_iclk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_char  <= 4'd0;
            r_msg   <= 32'd0;
            r_shift <= 7'd0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_char  <= w_char_nxt;
            r_msg   <= w_msg_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.o_tx   = r_tx;
    assign bus.o_busy = r_busy;
    assign bus.o_done = r_done;
endmodule

// File: tb/tb_bcd_uart_tx.sv
// tb/tb_bcd_uart_tx.sv - table-driven bench for bcd_uart_tx, CR LF and digits-only builds
module tb_bcd_uart_tx;
    localparam int C = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_uart_tx_if ifa();
    bcd_uart_tx_if ifb();

    bcd_uart_tx #(.CLKS_PER_BIT(C), .APPEND_CRLF(1'b1)) dut_a (
        .i_iclk(clk), .i_rst(rst), .bus(ifa.slave));
    bcd_uart_tx #(.CLKS_PER_BIT(C), .APPEND_CRLF(1'b0)) dut_b (
        .i_iclk(clk), .i_rst(rst), .bus(ifb.slave));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          sel;
        logic [31:0] digits;
        logic [79:0] str;
        int          n;
        bit          mid;
        bit          pulse_done;
        int          gap;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int s, input logic st, input logic [31:0] d);
        if (s == 0) begin
            ifa.i_start = st; ifa.i_digits = d;
        end else begin
            ifb.i_start = st; ifb.i_digits = d;
        end
    endtask

    function automatic logic [2:0] obs(input int s);
        if (s == 0) return {ifa.o_tx, ifa.o_busy, ifa.o_done};
        return {ifb.o_tx, ifb.o_busy, ifb.o_done};
    endfunction

    task automatic send_msg(input int s, input logic [31:0] dig, input logic [79:0] str,
                            input int n, input bit mid, input bit pulse_done, input int gap);
        logic       bits[100];
        logic [2:0] o;
        logic [9:0] f;
        logic [9:0] ef;
        int         errs;
        drive(s, 1'b1, dig);
        @(negedge clk);
        drive(s, 1'b0, dig);
        o = obs(s);
        check("start_edge", 64'({o[2], o[1], o[0]}), 64'(3'b010));
        bits[0] = o[2];
        errs = 0;
        for (int k = 1; k < n * 40; k++) begin
            @(negedge clk);
            o = obs(s);
            if (k % 4 == 2) bits[k / 4] = o[2];
            if (o[1] !== 1'b1 || o[0] !== 1'b0) errs++;
            if (mid && k == 100) drive(s, 1'b1, 32'h99999999);
            if (mid && k == 101) drive(s, 1'b0, 32'h99999999);
        end
        check("busy_no_early_done", 64'(errs), 64'd0);
        @(negedge clk);
        o = obs(s);
        check("done_pulse_busy_low", 64'(o), 64'(3'b101));
        if (pulse_done) drive(s, 1'b1, dig);
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < 10; i++) f[i] = bits[c * 10 + i];
            ef = {1'b1, str[(n - 1 - c) * 8 +: 8], 1'b0};
            check($sformatf("char%0d_frame", c), 64'(f), 64'(ef));
        end
        @(negedge clk);
        drive(s, 1'b0, dig);
        o = obs(s);
        check("after_done_idle", 64'(o), 64'(3'b100));
        errs = 0;
        for (int k = 0; k < gap; k++) begin
            @(negedge clk);
            if (obs(s) !== 3'b100) errs++;
        end
        if (gap > 0) check("idle_gap", 64'(errs), 64'd0);
    endtask

    initial begin
        int         errs;
        logic [2:0] o;
        vecs[0] = '{0, 32'h12345678, "12345678\r\n", 10, 1'b0, 1'b1, 20};
        vecs[1] = '{1, 32'h09AF0000, "09??0000",      8, 1'b0, 1'b1, 20};
        vecs[2] = '{0, 32'h87654321, "87654321\r\n", 10, 1'b1, 1'b0, 0};
        vecs[3] = '{0, 32'h00000000, "00000000\r\n", 10, 1'b0, 1'b0, 20};
        vecs[4] = '{1, 32'hFEDCBA98, "??????98",      8, 1'b0, 1'b0, 20};

        drive(0, 1'b0, 32'h0);
        drive(1, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        check("reset_state_a", 64'(obs(0)), 64'(3'b100));
        check("reset_state_b", 64'(obs(1)), 64'(3'b100));
        rst = 1'b0;
        errs = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (obs(0) !== 3'b100 || obs(1) !== 3'b100) errs++;
        end
        check("reset_idle_1000", 64'(errs), 64'd0);

        for (int v = 0; v < 5; v++)
            send_msg(vecs[v].sel, vecs[v].digits, vecs[v].str, vecs[v].n,
                     vecs[v].mid, vecs[v].pulse_done, vecs[v].gap);

        // Abort during data bit 3 of character 2 ('3' = 0x33, bit 3 is 0)
        drive(0, 1'b1, 32'h12345678);
        @(negedge clk);
        drive(0, 1'b0, 32'h12345678);
        repeat (97) @(negedge clk);
        o = obs(0);
        check("pre_reset_tx_low", 64'(o), 64'(3'b010));
        #1 rst = 1'b1;
        #1 check("async_reset_outputs", 64'(obs(0)), 64'(3'b100));
        @(negedge clk);
        rst = 1'b0;
        errs = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (obs(0) !== 3'b100) errs++;
        end
        check("post_reset_idle", 64'(errs), 64'd0);
        send_msg(0, 32'h24681357, "24681357\r\n", 10, 1'b0, 1'b0, 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
